// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD up/down counter.
package bcd_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_CLEAR = 2'b01,
        MODE_UP    = 2'b10,
        MODE_DOWN  = 2'b11
    } mode_e;

    // Out-of-range load digits are pinned to the largest legal BCD value.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle between the tick generator, the counter and the digit decoders.
interface bcd_updown_counter_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    tick;
    logic [1:0]              mode;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    ovf;
    logic                    tc;
    logic                    load_err;

    modport master (
        output tick, mode, load, load_val,
        input  digits, ovf, tc, load_err
    );

    modport slave (
        input  tick, mode, load, load_val,
        output digits, ovf, tc, load_err
    );
endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit of the ripple chain: steps by one when enabled and reports carry/borrow.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_value,
    input  logic               i_step,
    input  logic               i_down,
    output logic [DIGIT_W-1:0] o_next,
    output logic               o_carry
);

    always_comb begin
        o_next  = i_value;
        o_carry = 1'b0;
        if (i_step) begin
            if (i_down) begin
                if (i_value == '0) begin
                    o_next  = BCD_MAX;
                    o_carry = 1'b1;
                end else begin
                    o_next = i_value - 4'd1;
                end
            end else begin
                if (i_value >= BCD_MAX) begin
                    o_next  = '0;
                    o_carry = 1'b1;
                end else begin
                    o_next = i_value + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised BCD up/down counter with load, clear, and saturate-or-wrap terminal handling.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter bit WRAP       = 1'b0
) (
    input  logic                clk,
    input  logic                Rbutton,
    bcd_updown_counter_if.slave bus
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    logic [W-1:0]          r_digits;
    logic                  r_ovf;
    logic                  r_tc;
    logic                  r_load_err;

    logic [W-1:0]          w_next;
    logic [W-1:0]          w_clamped;
    logic [NUM_DIGITS:0]   w_step;
    logic [NUM_DIGITS-1:0] w_bad;
    logic                  w_down;
    logic                  w_load_bad;
    logic                  w_carry_out;

    // Digit 0 always steps; enable gating happens at the register, so the chain stays purely combinational.
    assign w_step[0] = 1'b1;
    assign w_down    = bus.mode[0];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .i_value (r_digits[g*DIGIT_W +: DIGIT_W]),
            .i_step  (w_step[g]),
            .i_down  (w_down),
            .o_next  (w_next[g*DIGIT_W +: DIGIT_W]),
            .o_carry (w_step[g+1])
        );

        assign w_bad[g]                         = (bus.load_val[g*DIGIT_W +: DIGIT_W] > BCD_MAX);
        assign w_clamped[g*DIGIT_W +: DIGIT_W]  = clamp_digit(bus.load_val[g*DIGIT_W +: DIGIT_W]);
    end

    assign w_load_bad  = |w_bad;
    assign w_carry_out = w_step[NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (Rbutton) begin
            r_digits   <= '0;
            r_ovf      <= 1'b0;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
            if (bus.load) begin
                r_digits   <= w_clamped;
                r_ovf      <= 1'b0;
                r_load_err <= w_load_bad;
            end else if (bus.mode == MODE_CLEAR) begin
                r_digits <= '0;
                r_ovf    <= 1'b0;
            end else if (bus.mode[1] && bus.tick) begin
                // A saturating counter at its terminal value keeps its digits and only raises ovf.
                if (!w_carry_out || WRAP) begin
                    r_digits <= w_next;
                end
                if (w_carry_out) begin
                    if (WRAP) begin
                        r_tc <= 1'b1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.digits   = r_digits;
    assign bus.ovf      = r_ovf;
    assign bus.tc       = r_tc;
    assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: four counter configurations share stimulus; an integer model predicts each one.
module tb_bcd_updown_counter;

    logic        clk;
    logic        s_rst;
    logic        s_tick;
    logic [1:0]  s_mode;
    logic        s_load;
    logic [31:0] s_lv;

    // Instances: A=6 digits saturate, B=6 digits wrap, C=1 digit saturate, D=8 digits wrap.
    bcd_updown_counter_if #(.NUM_DIGITS(6)) if_a ();
    bcd_updown_counter_if #(.NUM_DIGITS(6)) if_b ();
    bcd_updown_counter_if #(.NUM_DIGITS(1)) if_c ();
    bcd_updown_counter_if #(.NUM_DIGITS(8)) if_d ();

    bcd_updown_counter #(.NUM_DIGITS(6), .WRAP(1'b0)) u_a (.clk(clk), .Rbutton(s_rst), .bus(if_a));
    bcd_updown_counter #(.NUM_DIGITS(6), .WRAP(1'b1)) u_b (.clk(clk), .Rbutton(s_rst), .bus(if_b));
    bcd_updown_counter #(.NUM_DIGITS(1), .WRAP(1'b0)) u_c (.clk(clk), .Rbutton(s_rst), .bus(if_c));
    bcd_updown_counter #(.NUM_DIGITS(8), .WRAP(1'b1)) u_d (.clk(clk), .Rbutton(s_rst), .bus(if_d));

    assign if_a.tick = s_tick;  assign if_a.mode = s_mode;  assign if_a.load = s_load;  assign if_a.load_val = s_lv[23:0];
    assign if_b.tick = s_tick;  assign if_b.mode = s_mode;  assign if_b.load = s_load;  assign if_b.load_val = s_lv[23:0];
    assign if_c.tick = s_tick;  assign if_c.mode = s_mode;  assign if_c.load = s_load;  assign if_c.load_val = s_lv[3:0];
    assign if_d.tick = s_tick;  assign if_d.mode = s_mode;  assign if_d.load = s_load;  assign if_d.load_val = s_lv;

    logic [3:0][31:0] act_dig;
    logic [3:0]       act_ovf, act_tc, act_le;
    assign act_dig[0] = {8'h00, if_a.digits};
    assign act_dig[1] = {8'h00, if_b.digits};
    assign act_dig[2] = {28'h0, if_c.digits};
    assign act_dig[3] = if_d.digits;
    assign act_ovf = {if_d.ovf, if_c.ovf, if_b.ovf, if_a.ovf};
    assign act_tc  = {if_d.tc, if_c.tc, if_b.tc, if_a.tc};
    assign act_le  = {if_d.load_err, if_c.load_err, if_b.load_err, if_a.load_err};

    typedef struct packed {
        logic [3:0][31:0] dig;
        logic [3:0]       ovf;
        logic [3:0]       tc;
        logic [3:0]       le;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // ---------------- reference model: counts as plain integers ----------------
    int          nd[4] = '{6, 6, 1, 8};
    bit          wr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    longint      mv[4];
    bit          mo[4];

    function automatic longint p10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input longint v, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    task automatic model(input bit rst, input bit ld, input logic [1:0] md, input bit tk,
                         input logic [31:0] lv, output exp_t e);
        e = '0;
        for (int i = 0; i < 4; i++) begin
            longint mx = p10(nd[i]) - 1;
            if (rst) begin
                mv[i] = 0;
                mo[i] = 1'b0;
            end else if (ld) begin
                longint v = 0;
                for (int k = 0; k < nd[i]; k++) begin
                    int d = int'(lv[4*k +: 4]);
                    if (d > 9) begin
                        d = 9;
                        e.le[i] = 1'b1;
                    end
                    v = v + longint'(d) * p10(k);
                end
                mv[i] = v;
                mo[i] = 1'b0;
            end else if (md == 2'b01) begin
                mv[i] = 0;
                mo[i] = 1'b0;
            end else if (md[1] && tk) begin
                if (!md[0]) begin
                    if (mv[i] == mx) begin
                        if (wr[i]) begin mv[i] = 0; e.tc[i] = 1'b1; end
                        else mo[i] = 1'b1;
                    end else mv[i] = mv[i] + 1;
                end else begin
                    if (mv[i] == 0) begin
                        if (wr[i]) begin mv[i] = mx; e.tc[i] = 1'b1; end
                        else mo[i] = 1'b1;
                    end else mv[i] = mv[i] - 1;
                end
            end
            e.dig[i] = to_bcd(mv[i], nd[i]);
            e.ovf[i] = mo[i];
        end
    endtask

    // ---------------- driver: one stimulus cycle, expectation queued after the edge ----------------
    task automatic cyc(input bit rst, input bit ld, input logic [1:0] md, input bit tk, input logic [31:0] lv);
        exp_t e;
        @(negedge clk);
        s_rst  = rst;
        s_load = ld;
        s_mode = md;
        s_tick = tk;
        s_lv   = lv;
        model(rst, ld, md, tk, lv, e);
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    // ---------------- monitor: outputs are valid every cycle ----------------
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("dig[%0d]", i), act_dig[i], e.dig[i]);
                chk($sformatf("ovf[%0d]", i), 32'(act_ovf[i]), 32'(e.ovf[i]));
                chk($sformatf("tc[%0d]", i),  32'(act_tc[i]),  32'(e.tc[i]));
                chk($sformatf("le[%0d]", i),  32'(act_le[i]),  32'(e.le[i]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_rst = 1'b1; s_load = 1'b0; s_mode = 2'b00; s_tick = 1'b0; s_lv = '0;

        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 0, 2'b10, 1, 0);
        chk("reset_dig_A", act_dig[0], 32'h0);
        chk("reset_ovf_A", 32'(act_ovf[0]), 32'h0);

        for (int i = 0; i < 1234; i++) cyc(0, 0, 2'b10, 1, 0);
        chk("up1234_A", act_dig[0], 32'h001234);
        chk("up1234_ovf_A", 32'(act_ovf[0]), 32'h0);
        chk("up1234_D", act_dig[3], 32'h00001234);
        chk("sat1_C", act_dig[2], 32'h9);
        chk("sat1_ovf_C", 32'(act_ovf[2]), 32'h1);

        cyc(0, 1, 2'b00, 0, 32'h99999998);
        chk("ld998_A", act_dig[0], 32'h999998);
        cyc(0, 0, 2'b10, 1, 0);
        chk("sat_t1_A", act_dig[0], 32'h999999);
        chk("sat_t1_ovf", 32'(act_ovf[0]), 32'h0);
        cyc(0, 0, 2'b10, 1, 0);
        chk("sat_t2_A", act_dig[0], 32'h999999);
        chk("sat_t2_ovf", 32'(act_ovf[0]), 32'h1);
        cyc(0, 0, 2'b10, 1, 0);
        chk("sat_t3_A", act_dig[0], 32'h999999);
        cyc(0, 0, 2'b11, 1, 0);
        chk("sat_dn_A", act_dig[0], 32'h999998);
        chk("sat_dn_ovf", 32'(act_ovf[0]), 32'h1);

        cyc(0, 1, 2'b00, 0, 32'h99999999);
        cyc(0, 0, 2'b10, 1, 0);
        chk("wrap_up_B", act_dig[1], 32'h000000);
        chk("wrap_up_tc_B", 32'(act_tc[1]), 32'h1);
        chk("wrap_up_D", act_dig[3], 32'h0);
        chk("wrap_up_tc_D", 32'(act_tc[3]), 32'h1);
        cyc(0, 0, 2'b00, 1, 0);
        chk("wrap_hold_tc_B", 32'(act_tc[1]), 32'h0);
        cyc(0, 0, 2'b11, 1, 0);
        chk("wrap_dn_B", act_dig[1], 32'h999999);
        chk("wrap_dn_tc_B", 32'(act_tc[1]), 32'h1);
        cyc(0, 0, 2'b11, 0, 0);
        chk("wrap_idle_tc_B", 32'(act_tc[1]), 32'h0);

        cyc(0, 1, 2'b00, 0, 32'h0000F3A7);
        chk("clamp_A", act_dig[0], 32'h009397);
        chk("clamp_le_A", 32'(act_le[0]), 32'h1);
        cyc(0, 0, 2'b00, 0, 0);
        chk("clamp_le_off_A", 32'(act_le[0]), 32'h0);

        cyc(0, 1, 2'b01, 1, 32'h00456789);
        chk("prio_load_A", act_dig[0], 32'h456789);
        cyc(1, 1, 2'b10, 1, 32'h00456789);
        chk("prio_rst_A", act_dig[0], 32'h0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 2'b10, 1, 0);
        cyc(1, 0, 2'b10, 1, 0);
        chk("prio_rst_mid_A", act_dig[0], 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] lv;
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      lv = 32'h99999999;
            else if (sel == 1) lv = 32'h99999998;
            else if (sel == 2) lv = 32'h00000001;
            else begin
                for (int k = 0; k < 8; k++)
                    lv[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            end
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), lv);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD counter that succeeds the fixed six-digit up-counter in the stopwatch/display path. It adds a configurable digit count, up and down counting, parallel load, a count-enable strobe, and a choice of saturating or wrapping terminal behaviour. The counter sits between the clock-divider tick generator and the per-digit seven-segment decoders. It drives one 4-bit BCD nibble per display digit.

## Interface
Parameters:
- NUM_DIGITS, 6, number of BCD digits (1..8).
- WRAP, 0, terminal behaviour: 0 = saturate and set sticky `ovf`; 1 = wrap around and pulse `tc`.

Ports (clock and reset first):
- clk  in  1  sole clock; all state changes on the rising edge.
- Rbutton  in  1  reset; synchronous, active-high.
- tick  in  1  count-enable strobe; one count step per cycle in which it is high.
- mode  in  2  00 hold, 01 clear, 10 count up, 11 count down.
- load  in  1  parallel load strobe.
- load_val  in  4*NUM_DIGITS  load value; digit k is bits [4k+3:4k].
- digits  out  4*NUM_DIGITS  current count; digit 0 is least significant.
- ovf  out  1  sticky over/underflow flag (WRAP=0 only; tied 0 when WRAP=1).
- tc  out  1  one-cycle terminal-count pulse on wrap (WRAP=1 only; tied 0 when WRAP=0).
- load_err  out  1  one-cycle pulse when a load contained a digit greater than 9.

## Operation
- Per-cycle priority: Rbutton > load > mode 01 (clear) > count (mode 1x with tick=1) > hold.
- Rbutton:
  - digits = 0, ovf = 0, tc = 0, load_err = 0.
  - Takes effect on the next edge, even mid-count or mid-load.
- load:
  - Each digit takes load_val[k].
  - Any digit greater than 9 is replaced by 9, and load_err pulses.
  - ovf is cleared.
  - tick and mode are ignored that cycle.
- Clear (mode 01): digits = 0 and ovf = 0, regardless of tick.
- Hold (mode 00, or mode 1x with tick=0): all state is unchanged.
- Count up:
  - Digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit; ripple is combinational within the cycle.
  - Carry out of the top digit at all-9s:
    - WRAP=0: digits stay all 9, and ovf is set and remains set.
    - WRAP=1: digits become all 0, and tc pulses.
- Count down:
  - A digit at 0 borrows and becomes 9.
  - Borrow out of the top digit at all-0s:
    - WRAP=0: digits stay 0, and ovf is set.
    - WRAP=1: digits become all 9, and tc pulses.
- Saturated counter (WRAP=0):
  - Counting in the opposite direction proceeds normally.
  - ovf stays set until Rbutton, load, or clear.
- Arithmetic is pure BCD; a digit value of 10..15 is unreachable from reset.

## Timing
- All outputs are registered.
- Latency: tick sampled at edge N gives the new `digits` after edge N; one cycle.
- tc and load_err are high for exactly the one cycle following the causing edge.
  - Back-to-back wraps produce back-to-back pulses.
- Mode changes take effect on the first edge at which they are sampled; no pipelining and no debounce (debounce is handled upstream).
- Full ripple carry/borrow across all digits is combinational and must close timing at 50 MHz for NUM_DIGITS=8.

## Structure
- Package `bcd_pkg`:
  - mode encodings MODE_HOLD, MODE_CLEAR, MODE_UP, MODE_DOWN;
  - BCD_MAX = 4'd9;
  - digit width constant 4.
- Sub-module `bcd_digit`, instantiated NUM_DIGITS times in a generate loop:
  - inputs: value, step enable (carry/borrow in), direction;
  - outputs: next value, carry/borrow out.
- Top level owns priority muxing, load clamping, saturation/wrap handling, and the flag registers.

## Test plan
- Reset and up-count:
  - Assert Rbutton, then count up with 1234 ticks (NUM_DIGITS=6).
  - Required: digits = 001234, ovf = 0.
- Saturation (WRAP=0):
  - Load 999998, then 3 up-ticks.
  - Required: digits = 999999 and ovf = 1 from the second tick; a subsequent down-tick gives 999998 with ovf still 1.
- Wrap both directions (WRAP=1):
  - Load 999999, 1 up-tick.
  - Required: digits = 000000, tc high for exactly one cycle; then 1 down-tick gives 999999 and another single tc pulse.
- Load clamp:
  - load_val = 0x00F3A7.
  - Required: digits = 009397, load_err pulses once.
- Priority:
  - Assert load, mode = 01 and tick together.
  - Required: the load value is taken.
  - Then assert Rbutton with load: digits = 0.
  - Then assert Rbutton mid-count: the next cycle reads all 0.
- Parameter sweep:
  - NUM_DIGITS = 1, 8: up-count across the top-digit carry.
  - Required: correct saturate/wrap at 9 and at 99999999 respectively.
